// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetches one word per request from instruction memory,
// presents it to the decoder, and resolves branch/JR/halt on accept.
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [15:0] imem_rdata,
  input  logic        imem_rdy,
  output logic [15:0] instr,
  output logic        instr_vld,
  output logic [15:0] pc_plus1,
  input  logic        stall,
  input  logic        branch,
  input  logic        jr,
  input  logic        halt,
  input  logic [2:0]  cond,
  input  logic [15:0] imm,
  input  logic [15:0] jr_target,
  input  logic [2:0]  flags,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    VALID  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] pc_r, pc_s;
  logic [15:0] addr_r, addr_s;
  logic        rd_en_r, rd_en_s;
  logic [15:0] instr_r, instr_s;
  logic        vld_r, vld_s;
  logic [15:0] pc_plus1_r, pc_plus1_s;
  logic        halted_r, halted_s;
  logic [15:0] target_s;

  // flags are packed {Z,V,N}
  function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
    logic z;
    logic v;
    logic n;
    logic res;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'b000:  res = ~z;
      3'b001:  res = z;
      3'b010:  res = ~z & ~n;
      3'b011:  res = n;
      3'b100:  res = z | ~n;
      3'b101:  res = n | z;
      3'b110:  res = v;
      3'b111:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Redirect target for the presented instruction; jr only redirects together with branch.
  always_comb begin
    target_s = pc_plus1_r;
    if (branch && jr) begin
      target_s = jr_target;
    end else if (branch && cond_true(cond, flags)) begin
      target_s = pc_plus1_r + imm;
    end else begin
      target_s = pc_plus1_r;
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    addr_s     = addr_r;
    rd_en_s    = 1'b0;
    instr_s    = instr_r;
    vld_s      = 1'b0;
    pc_plus1_s = pc_plus1_r;
    halted_s   = 1'b0;
    case (state_r)
      IDLE: begin
        state_s = FETCH;
        rd_en_s = 1'b1;
        addr_s  = pc_r;
      end
      FETCH: begin
        if (imem_rdy) begin
          state_s    = VALID;
          instr_s    = imem_rdata;
          pc_plus1_s = pc_r + 16'd1;
          vld_s      = 1'b1;
        end else begin
          rd_en_s = 1'b1;
          addr_s  = pc_r;
        end
      end
      VALID: begin
        if (stall) begin
          vld_s = 1'b1;
        end else if (halt) begin
          state_s  = HALTED;
          halted_s = 1'b1;
        end else begin
          state_s = FETCH;
          pc_s    = target_s;
          addr_s  = target_s;
          rd_en_s = 1'b1;
        end
      end
      HALTED: begin
        halted_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, PC and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pc_r       <= 16'h0000;
      addr_r     <= 16'h0000;
      rd_en_r    <= 1'b0;
      instr_r    <= 16'h0000;
      vld_r      <= 1'b0;
      pc_plus1_r <= 16'h0000;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      addr_r     <= addr_s;
      rd_en_r    <= rd_en_s;
      instr_r    <= instr_s;
      vld_r      <= vld_s;
      pc_plus1_r <= pc_plus1_s;
      halted_r   <= halted_s;
    end
  end

  assign imem_addr  = addr_r;
  assign imem_rd_en = rd_en_r;
  assign instr      = instr_r;
  assign instr_vld  = vld_r;
  assign pc_plus1   = pc_plus1_r;
  assign halted     = halted_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized memory latency, stalls and
// control flow checked against a PC-level reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_rdata;
  logic        imem_rdy;
  logic [15:0] instr;
  logic        instr_vld;
  logic [15:0] pc_plus1;
  logic        stall;
  logic        branch;
  logic        jr;
  logic        halt;
  logic [2:0]  cond;
  logic [15:0] imm;
  logic [15:0] jr_target;
  logic [2:0]  flags;
  logic        halted;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] mem [65536];
  logic [15:0] m_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .imem_rdata(imem_rdata), .imem_rdy(imem_rdy),
    .instr(instr), .instr_vld(instr_vld), .pc_plus1(pc_plus1),
    .stall(stall), .branch(branch), .jr(jr), .halt(halt),
    .cond(cond), .imm(imm), .jr_target(jr_target), .flags(flags),
    .halted(halted)
  );

  // Reference next-PC rule, from the condition truth table and mod-2^16 arithmetic.
  function automatic logic [15:0] ref_next(input logic [15:0] pc, input logic br, input logic j,
                                           input logic [2:0] c, input logic [15:0] im,
                                           input logic [15:0] jt, input logic [2:0] fl);
    bit z;
    bit v;
    bit n;
    bit tbl [8];
    int pc1;
    z = fl[2];
    v = fl[1];
    n = fl[0];
    tbl = '{!z, z, !z && !n, n, z || !n, n || z, v, 1'b1};
    pc1 = (int'(pc) + 1) % 65536;
    if (br && j) return jt;
    if (br && tbl[c]) return 16'((pc1 + int'(im)) % 65536);
    return 16'(pc1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    stall = 1'b0; branch = 1'b0; jr = 1'b0; halt = 1'b0;
    cond = 3'd0; imm = 16'h0000; jr_target = 16'h0000; flags = 3'd0;
  endtask

  // One full fetch/present/accept transaction starting in FETCH at model PC.
  task automatic do_fetch(input int waits, input int stalls, input logic br, input logic j,
                          input logic h, input logic [2:0] c, input logic [15:0] im,
                          input logic [15:0] jt, input logic [2:0] fl);
    logic [15:0] exp_instr;
    logic [15:0] pc1;
    logic [15:0] nxt;
    exp_instr = mem[m_pc];
    pc1 = 16'((int'(m_pc) + 1) % 65536);
    total_cnt++;
    if ({imem_rd_en, instr_vld, halted, imem_addr} !== {1'b1, 1'b0, 1'b0, m_pc})
      $display("FAIL fetch_req: rd_en=%b vld=%b halted=%b addr=%h expected 1 0 0 %h",
               imem_rd_en, instr_vld, halted, imem_addr, m_pc);
    else pass_cnt++;
    for (int i = 0; i < waits; i++) begin
      imem_rdy = 1'b0;
      imem_rdata = 16'($urandom);
      step();
      total_cnt++;
      if ({imem_rd_en, instr_vld, imem_addr} !== {1'b1, 1'b0, m_pc})
        $display("FAIL fetch_wait: rd_en=%b vld=%b addr=%h expected 1 0 %h",
                 imem_rd_en, instr_vld, imem_addr, m_pc);
      else pass_cnt++;
    end
    imem_rdy = 1'b1;
    imem_rdata = exp_instr;
    step();
    imem_rdy = 1'b0;
    imem_rdata = 16'($urandom);
    total_cnt++;
    if ({instr_vld, imem_rd_en, instr, pc_plus1} !== {1'b1, 1'b0, exp_instr, pc1})
      $display("FAIL present: vld=%b rd_en=%b instr=%h pc_plus1=%h expected 1 0 %h %h",
               instr_vld, imem_rd_en, instr, pc_plus1, exp_instr, pc1);
    else pass_cnt++;
    for (int i = 0; i < stalls; i++) begin
      stall = 1'b1;
      branch = 1'($urandom); jr = 1'($urandom); halt = 1'($urandom);
      jr_target = 16'($urandom);
      step();
      total_cnt++;
      if ({instr_vld, imem_rd_en, halted, instr, pc_plus1} !== {1'b1, 1'b0, 1'b0, exp_instr, pc1})
        $display("FAIL stall_hold: vld=%b rd_en=%b halted=%b instr=%h pc_plus1=%h expected 1 0 0 %h %h",
                 instr_vld, imem_rd_en, halted, instr, pc_plus1, exp_instr, pc1);
      else pass_cnt++;
    end
    stall = 1'b0; branch = br; jr = j; halt = h;
    cond = c; imm = im; jr_target = jt; flags = fl;
    step();
    clear_dec();
    if (h) begin
      total_cnt++;
      if ({halted, instr_vld, imem_rd_en} !== 3'b100)
        $display("FAIL halt_accept: halted/vld/rd_en=%b%b%b expected 100", halted, instr_vld, imem_rd_en);
      else pass_cnt++;
    end else begin
      nxt = ref_next(m_pc, br, j, c, im, jt, fl);
      m_pc = nxt;
      total_cnt++;
      if ({imem_rd_en, instr_vld, imem_addr} !== {1'b1, 1'b0, nxt})
        $display("FAIL next_pc: rd_en=%b vld=%b addr=%h expected 1 0 %h",
                 imem_rd_en, instr_vld, imem_addr, nxt);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_dec();
    imem_rdy = 1'b0;
    imem_rdata = 16'h0000;
    #2;
    total_cnt++;
    if ({imem_addr, imem_rd_en, instr, instr_vld, pc_plus1, halted} !== 51'd0)
      $display("FAIL reset_values: addr=%h rd_en=%b instr=%h vld=%b pc_plus1=%h halted=%b expected all 0",
               imem_addr, imem_rd_en, instr, instr_vld, pc_plus1, halted);
    else pass_cnt++;
    step();
    step();
    rst_n = 1'b1;
    m_pc = 16'h0000;
    #1;
    total_cnt++;
    if (imem_rd_en !== 1'b0)
      $display("FAIL reset_release: rd_en=%b expected 0 before first edge", imem_rd_en);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({imem_rd_en, imem_addr} !== {1'b1, 16'h0000})
      $display("FAIL first_fetch: rd_en=%b addr=%h expected 1 0000", imem_rd_en, imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (imem_addr !== 16'(k))
        $display("FAIL seq_addr: addr=%h expected %h", imem_addr, 16'(k));
      else pass_cnt++;
      do_fetch(0, 0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0);
    end
    do_fetch(0, 0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0);
  endtask

  task automatic test_wait();
    total_cnt++;
    if (imem_addr !== 16'h0005)
      $display("FAIL wait_start: addr=%h expected 0005", imem_addr);
    else pass_cnt++;
    do_fetch(3, 0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0);
  endtask

  task automatic test_stall();
    do_fetch(0, 5, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0);
  endtask

  task automatic test_branch();
    do_fetch(0, 0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0F00, 3'd0);
    total_cnt++;
    if (imem_addr !== 16'h0F00) $display("FAIL jr_target: addr=%h expected 0f00", imem_addr);
    else pass_cnt++;
    do_fetch(1, 0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0010, 3'd0);
    do_fetch(0, 0, 1'b1, 1'b0, 1'b0, 3'b001, 16'hFFFC, 16'h0000, 3'b100);
    total_cnt++;
    if (imem_addr !== 16'h000D) $display("FAIL branch_taken: addr=%h expected 000d", imem_addr);
    else pass_cnt++;
    do_fetch(0, 0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 16'h0010, 3'd0);
    do_fetch(0, 1, 1'b1, 1'b0, 1'b0, 3'b001, 16'hFFFC, 16'h0000, 3'b000);
    total_cnt++;
    if (imem_addr !== 16'h0011) $display("FAIL branch_not_taken: addr=%h expected 0011", imem_addr);
    else pass_cnt++;
    do_fetch(0, 0, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 16'hFFFF, 3'd0);
    do_fetch(2, 0, 1'b1, 1'b0, 1'b0, 3'b111, 16'h0000, 16'h0000, 3'b000);
    total_cnt++;
    if (imem_addr !== 16'h0000) $display("FAIL pc_wrap: addr=%h expected 0000", imem_addr);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 150; k++) begin
      do_fetch($urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom),
               ($urandom_range(0, 3) == 0), 1'b0, 3'($urandom), 16'($urandom),
               16'($urandom), 3'($urandom));
    end
  endtask

  task automatic test_halt();
    do_fetch(1, 1, 1'b1, 1'b1, 1'b1, 3'b111, 16'h0040, 16'h1234, 3'b111);
    for (int k = 0; k < 20; k++) begin
      imem_rdy = 1'($urandom);
      stall = 1'($urandom);
      branch = 1'($urandom);
      step();
      total_cnt++;
      if ({halted, instr_vld, imem_rd_en} !== 3'b100)
        $display("FAIL halted_hold: halted/vld/rd_en=%b%b%b expected 100 at cycle %0d",
                 halted, instr_vld, imem_rd_en, k);
      else pass_cnt++;
    end
    clear_dec();
    imem_rdy = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_pc = 16'h0000;
    step();
    do_fetch(0, 0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0);
    imem_rdy = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if ({imem_addr, imem_rd_en, instr, instr_vld, pc_plus1, halted} !== 51'd0)
      $display("FAIL reset_async: addr=%h rd_en=%b instr=%h vld=%b pc_plus1=%h halted=%b expected all 0",
               imem_addr, imem_rd_en, instr, instr_vld, pc_plus1, halted);
    else pass_cnt++;
    imem_rdy = 1'b1;
    imem_rdata = 16'hDEAD;
    step();
    rst_n = 1'b1;
    step();
    total_cnt++;
    if ({imem_rd_en, instr_vld, imem_addr, instr} !== {1'b1, 1'b0, 16'h0000, 16'h0000})
      $display("FAIL late_rdy: rd_en=%b vld=%b addr=%h instr=%h expected 1 0 0000 0000",
               imem_rd_en, instr_vld, imem_addr, instr);
    else pass_cnt++;
    imem_rdy = 1'b0;
    m_pc = 16'h0000;
    do_fetch(1, 0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom) | 16'h0001;
    mem[6] = 16'hA123;
    test_reset();
    test_sequential();
    test_wait();
    test_stall();
    test_branch();
    test_random();
    test_halt();
    test_reset_midfetch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
